// File: rtl/up_axi_master_pkg.sv
// Shared types and constants for the up bus to AXI4-Lite initiator.
package up_axi_master_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Any response other than OKAY is reported to the requester as an error
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/up_axi_master.sv
// Converts up register bus requests into single outstanding AXI4-Lite
// master transactions, with a response timeout guarding against hung slaves.
module up_axi_master
  import up_axi_master_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 1023
) (
  input  logic                         up_clk,
  input  logic                         up_rstn,

  input  logic                         up_wreq,
  input  logic [13:0]                  up_waddr,
  input  logic [31:0]                  up_wdata,
  output logic                         up_wack,
  output logic                         up_werr,

  input  logic                         up_rreq,
  input  logic [13:0]                  up_raddr,
  output logic [31:0]                  up_rdata,
  output logic                         up_rack,
  output logic                         up_rerr,

  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                   m_axi_awprot,

  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  output logic [31:0]                  m_axi_wdata,
  output logic [3:0]                   m_axi_wstrb,

  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  input  logic [1:0]                   m_axi_bresp,

  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                   m_axi_arprot,

  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic [31:0]                  m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp
);

  // A disabled timeout still needs a legal one-bit counter
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           timeout_hit;

  logic                           awvalid_d, wvalid_d, bready_d;
  logic                           arvalid_d, rready_d;
  logic [AXI_ADDRESS_WIDTH-1:0]   awaddr_d, araddr_d;
  logic [31:0]                    wdata_d, rdata_d;
  logic                           wack_d, werr_d, rack_d, rerr_d;

  // Protection and strobes never change: unprivileged, secure, full words
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hf;

  // Abort condition; a zero TIMEOUT_CYCLES means wait forever
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Next-state and next-output logic; every output is a register so the
  // values computed here only become visible after the following edge
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    awvalid_d = m_axi_awvalid;
    wvalid_d  = m_axi_wvalid;
    bready_d  = m_axi_bready;
    arvalid_d = m_axi_arvalid;
    rready_d  = m_axi_rready;
    awaddr_d  = m_axi_awaddr;
    araddr_d  = m_axi_araddr;
    wdata_d   = m_axi_wdata;
    rdata_d   = up_rdata;
    wack_d    = 1'b0;
    rack_d    = 1'b0;
    werr_d    = up_werr;
    rerr_d    = up_rerr;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (up_wreq) begin
          state_d   = WRITE;
          awaddr_d  = AXI_ADDRESS_WIDTH'({up_waddr, 2'b00});
          wdata_d   = up_wdata;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          bready_d  = 1'b1;
        end else if (up_rreq) begin
          state_d   = READ;
          araddr_d  = AXI_ADDRESS_WIDTH'({up_raddr, 2'b00});
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
        end
      end

      WRITE: begin
        if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (m_axi_awvalid && m_axi_awready) begin
          awvalid_d = 1'b0;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          wvalid_d = 1'b0;
        end
        if (m_axi_bvalid && m_axi_bready) begin
          werr_d    = resp_is_err(m_axi_bresp);
          wack_d    = 1'b1;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b0;
          state_d   = ACK;
        end else if (timeout_hit) begin
          werr_d    = 1'b1;
          wack_d    = 1'b1;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b0;
          state_d   = ACK;
        end
      end

      READ: begin
        if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (m_axi_arvalid && m_axi_arready) begin
          arvalid_d = 1'b0;
        end
        if (m_axi_rvalid && m_axi_rready) begin
          rdata_d   = m_axi_rdata;
          rerr_d    = resp_is_err(m_axi_rresp);
          rack_d    = 1'b1;
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          state_d   = ACK;
        end else if (timeout_hit) begin
          rdata_d   = 32'h0;
          rerr_d    = 1'b1;
          rack_d    = 1'b1;
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          state_d   = ACK;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any transaction silently
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_araddr  <= '0;
      m_axi_wdata   <= 32'h0;
      up_rdata      <= 32'h0;
      up_wack       <= 1'b0;
      up_rack       <= 1'b0;
      up_werr       <= 1'b0;
      up_rerr       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
      m_axi_awaddr  <= awaddr_d;
      m_axi_araddr  <= araddr_d;
      m_axi_wdata   <= wdata_d;
      up_rdata      <= rdata_d;
      up_wack       <= wack_d;
      up_rack       <= rack_d;
      up_werr       <= werr_d;
      up_rerr       <= rerr_d;
    end
  end

endmodule

// File: tb/tb_up_axi_master.sv
// Directed bench for up_axi_master with a small configurable AXI4-Lite slave.
module tb_up_axi_master;
  import up_axi_master_pkg::*;

  localparam int AW = 16;

  logic          up_clk;
  logic          up_rstn;
  logic          up_wreq;
  logic [13:0]   up_waddr;
  logic [31:0]   up_wdata;
  logic          up_wack;
  logic          up_werr;
  logic          up_rreq;
  logic [13:0]   up_raddr;
  logic [31:0]   up_rdata;
  logic          up_rack;
  logic          up_rerr;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [AW-1:0] m_axi_awaddr;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [31:0]   m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [31:0]   m_axi_rdata;
  logic [1:0]    m_axi_rresp;

  // Slave behaviour knobs
  logic          aw_ready_en, w_ready_en, ar_ready_en;
  logic [1:0]    bresp_cfg, rresp_cfg;
  logic [31:0]   rdata_cfg;
  logic          aw_done, w_done;

  int checks;
  int errors;
  int wack_cnt;
  int rack_cnt;
  int wack_base;
  int rack_base;

  up_axi_master #(
    .AXI_ADDRESS_WIDTH (AW),
    .TIMEOUT_CYCLES    (8)
  ) dut (
    .up_clk        (up_clk),
    .up_rstn       (up_rstn),
    .up_wreq       (up_wreq),
    .up_waddr      (up_waddr),
    .up_wdata      (up_wdata),
    .up_wack       (up_wack),
    .up_werr       (up_werr),
    .up_rreq       (up_rreq),
    .up_raddr      (up_raddr),
    .up_rdata      (up_rdata),
    .up_rack       (up_rack),
    .up_rerr       (up_rerr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp)
  );

  initial up_clk = 1'b0;
  always #5 up_clk = ~up_clk;

  assign m_axi_awready = aw_ready_en;
  assign m_axi_wready  = w_ready_en;
  assign m_axi_arready = ar_ready_en;
  assign m_axi_bresp   = bresp_cfg;
  assign m_axi_rresp   = rresp_cfg;
  assign m_axi_rdata   = rdata_cfg;

  // Slave: respond one cycle after both AW and W (or AR) have handshaken
  always @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      m_axi_bvalid <= 1'b0;
      m_axi_rvalid <= 1'b0;
    end else begin
      if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 1'b0;
      end else if (!m_axi_bvalid &&
                   (aw_done || (m_axi_awvalid && m_axi_awready)) &&
                   (w_done  || (m_axi_wvalid  && m_axi_wready))) begin
        m_axi_bvalid <= 1'b1;
        aw_done      <= 1'b0;
        w_done       <= 1'b0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
        if (m_axi_wvalid && m_axi_wready)   w_done  <= 1'b1;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        m_axi_rvalid <= 1'b0;
      end else if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
      end
    end
  end

  // Completion pulse counters
  always @(posedge up_clk) begin
    if (up_wack) wack_cnt <= wack_cnt + 1;
    if (up_rack) rack_cnt <= rack_cnt + 1;
  end

  // Global safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge up_clk);
  endtask

  task automatic applyStimulus(input logic wreq, input logic [13:0] waddr,
                               input logic [31:0] wdata, input logic rreq,
                               input logic [13:0] raddr);
    up_wreq  = wreq;
    up_waddr = waddr;
    up_wdata = wdata;
    up_rreq  = rreq;
    up_raddr = raddr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valids"},
                {27'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'h0);
    checkOutput({tag, "_acks"}, {28'h0, up_wack, up_rack, up_werr, up_rerr}, 32'h0);
    checkOutput({tag, "_awaddr"}, {16'h0, m_axi_awaddr}, 32'h0);
    checkOutput({tag, "_araddr"}, {16'h0, m_axi_araddr}, 32'h0);
    checkOutput({tag, "_wdata"}, m_axi_wdata, 32'h0);
    checkOutput({tag, "_rdata"}, up_rdata, 32'h0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    wack_cnt    = 0;
    rack_cnt    = 0;
    up_rstn     = 1'b0;
    aw_ready_en = 1'b1;
    w_ready_en  = 1'b1;
    ar_ready_en = 1'b1;
    bresp_cfg   = AXI_RESP_OKAY;
    rresp_cfg   = AXI_RESP_OKAY;
    rdata_cfg   = 32'h0;
    applyStimulus(1'b0, 14'h0, 32'h0, 1'b0, 14'h0);
    tick();
    tick();
    checkAllZero("rst_init");
    up_rstn = 1'b1;
    tick();

    // Reset asserted in the middle of a stalled write
    $display("[TB] reset mid-stream");
    aw_ready_en = 1'b0;
    w_ready_en  = 1'b0;
    applyStimulus(1'b1, 14'h0aaa, 32'hdeadbeef, 1'b0, 14'h0);
    tick();
    tick();
    checkOutput("pre_rst_awvalid", {31'h0, m_axi_awvalid}, 32'h1);
    up_rstn = 1'b0;
    applyStimulus(1'b0, 14'h0, 32'h0, 1'b0, 14'h0);
    #1;
    checkAllZero("rst_mid");
    tick();
    up_rstn     = 1'b1;
    aw_ready_en = 1'b1;
    w_ready_en  = 1'b1;
    tick();

    // Zero-wait write
    $display("[TB] zero-wait write");
    wack_base = wack_cnt;
    applyStimulus(1'b1, 14'h0040, 32'ha5a5_0001, 1'b0, 14'h0);
    tick();
    checkOutput("wr_awvalid", {31'h0, m_axi_awvalid}, 32'h1);
    checkOutput("wr_wvalid", {31'h0, m_axi_wvalid}, 32'h1);
    checkOutput("wr_awaddr", {16'h0, m_axi_awaddr}, 32'h0000_0100);
    checkOutput("wr_wdata", m_axi_wdata, 32'ha5a5_0001);
    checkOutput("wr_wstrb", {28'h0, m_axi_wstrb}, 32'hf);
    checkOutput("wr_awprot", {29'h0, m_axi_awprot}, 32'h0);
    checkOutput("wr_bready", {31'h0, m_axi_bready}, 32'h1);
    tick();
    checkOutput("wr_valids_clr", {30'h0, m_axi_awvalid, m_axi_wvalid}, 32'h0);
    checkOutput("wr_wack_early", {31'h0, up_wack}, 32'h0);
    tick();
    checkOutput("wr_wack", {31'h0, up_wack}, 32'h1);
    checkOutput("wr_werr", {31'h0, up_werr}, 32'h0);
    up_wreq = 1'b0;
    tick();
    checkOutput("wr_wack_pulse", {31'h0, up_wack}, 32'h0);
    tick();
    checkOutput("wr_no_reissue", {31'h0, m_axi_awvalid}, 32'h0);
    checkOutput("wr_wack_count", wack_cnt - wack_base, 32'd1);

    // Slave holds wready low for five cycles after the AW handshake
    $display("[TB] wready stall");
    wack_base  = wack_cnt;
    w_ready_en = 1'b0;
    applyStimulus(1'b1, 14'h0007, 32'h0000_beef, 1'b0, 14'h0);
    tick();
    tick();
    checkOutput("stall_awvalid_clr", {31'h0, m_axi_awvalid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    checkOutput("stall_wvalid_held", {31'h0, m_axi_wvalid}, 32'h1);
    checkOutput("stall_bready_held", {31'h0, m_axi_bready}, 32'h1);
    checkOutput("stall_no_wack", wack_cnt - wack_base, 32'd0);
    w_ready_en = 1'b1;
    tick();
    checkOutput("stall_wvalid_clr", {31'h0, m_axi_wvalid}, 32'h0);
    tick();
    checkOutput("stall_wack", {31'h0, up_wack}, 32'h1);
    up_wreq = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("stall_wack_count", wack_cnt - wack_base, 32'd1);

    // Write answered with DECERR
    $display("[TB] write error response");
    bresp_cfg = AXI_RESP_DECERR;
    applyStimulus(1'b1, 14'h0003, 32'h1111_2222, 1'b0, 14'h0);
    tick();
    tick();
    tick();
    checkOutput("decerr_wack", {31'h0, up_wack}, 32'h1);
    checkOutput("decerr_werr", {31'h0, up_werr}, 32'h1);
    up_wreq   = 1'b0;
    bresp_cfg = AXI_RESP_OKAY;
    tick();

    // Read with SLVERR response
    $display("[TB] read with slverr");
    rack_base = rack_cnt;
    rdata_cfg = 32'h1234_5678;
    rresp_cfg = AXI_RESP_SLVERR;
    applyStimulus(1'b0, 14'h0, 32'h0, 1'b1, 14'h0010);
    tick();
    checkOutput("rd_arvalid", {31'h0, m_axi_arvalid}, 32'h1);
    checkOutput("rd_araddr", {16'h0, m_axi_araddr}, 32'h0000_0040);
    checkOutput("rd_rready", {31'h0, m_axi_rready}, 32'h1);
    tick();
    checkOutput("rd_arvalid_clr", {31'h0, m_axi_arvalid}, 32'h0);
    tick();
    checkOutput("rd_rack", {31'h0, up_rack}, 32'h1);
    checkOutput("rd_rdata", up_rdata, 32'h1234_5678);
    checkOutput("rd_rerr", {31'h0, up_rerr}, 32'h1);
    up_rreq = 1'b0;
    tick();
    checkOutput("rd_rack_pulse", {31'h0, up_rack}, 32'h0);
    checkOutput("rd_rdata_held", up_rdata, 32'h1234_5678);
    checkOutput("rd_rack_count", rack_cnt - rack_base, 32'd1);
    rresp_cfg = AXI_RESP_OKAY;

    // Simultaneous write and read requests
    $display("[TB] simultaneous requests");
    wack_base = wack_cnt;
    rack_base = rack_cnt;
    rdata_cfg = 32'hcafe_f00d;
    applyStimulus(1'b1, 14'h0005, 32'h5555_aaaa, 1'b1, 14'h0006);
    tick();
    checkOutput("both_awvalid", {31'h0, m_axi_awvalid}, 32'h1);
    checkOutput("both_arvalid_wait", {31'h0, m_axi_arvalid}, 32'h0);
    checkOutput("both_awaddr", {16'h0, m_axi_awaddr}, 32'h0000_0014);
    tick();
    tick();
    checkOutput("both_wack", {31'h0, up_wack}, 32'h1);
    checkOutput("both_arvalid_wait2", {31'h0, m_axi_arvalid}, 32'h0);
    up_wreq = 1'b0;
    tick();
    checkOutput("both_ack_cycle_arvalid", {31'h0, m_axi_arvalid}, 32'h0);
    tick();
    checkOutput("both_arvalid", {31'h0, m_axi_arvalid}, 32'h1);
    checkOutput("both_araddr", {16'h0, m_axi_araddr}, 32'h0000_0018);
    tick();
    tick();
    checkOutput("both_rack", {31'h0, up_rack}, 32'h1);
    checkOutput("both_rdata", up_rdata, 32'hcafe_f00d);
    checkOutput("both_rerr", {31'h0, up_rerr}, 32'h0);
    up_rreq = 1'b0;
    tick();
    tick();
    checkOutput("both_wack_count", wack_cnt - wack_base, 32'd1);
    checkOutput("both_rack_count", rack_cnt - rack_base, 32'd1);

    // Hung slave: write aborted by the timeout
    $display("[TB] write timeout");
    aw_ready_en = 1'b0;
    w_ready_en  = 1'b0;
    applyStimulus(1'b1, 14'h0100, 32'h0f0f_0f0f, 1'b0, 14'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
    end
    checkOutput("tmo_before_valids", {29'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h7);
    checkOutput("tmo_before_wack", {31'h0, up_wack}, 32'h0);
    tick();
    checkOutput("tmo_valids_drop", {29'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'h0);
    checkOutput("tmo_wack", {31'h0, up_wack}, 32'h1);
    checkOutput("tmo_werr", {31'h0, up_werr}, 32'h1);
    up_wreq = 1'b0;
    tick();
    tick();
    checkOutput("tmo_idle", {29'h0, m_axi_awvalid, m_axi_wvalid, up_wack}, 32'h0);
    aw_ready_en = 1'b1;
    w_ready_en  = 1'b1;

    // Reset pulsed while AR is stalled, then a clean read
    $display("[TB] reset during read");
    rack_base   = rack_cnt;
    ar_ready_en = 1'b0;
    applyStimulus(1'b0, 14'h0, 32'h0, 1'b1, 14'h0123);
    tick();
    tick();
    checkOutput("rrst_arvalid_high", {31'h0, m_axi_arvalid}, 32'h1);
    checkOutput("rrst_araddr", {16'h0, m_axi_araddr}, 32'h0000_048c);
    up_rstn = 1'b0;
    up_rreq = 1'b0;
    #1;
    checkOutput("rrst_arvalid_async", {30'h0, m_axi_arvalid, m_axi_rready}, 32'h0);
    tick();
    up_rstn     = 1'b1;
    ar_ready_en = 1'b1;
    tick();
    tick();
    checkOutput("rrst_no_rack", rack_cnt - rack_base, 32'd0);
    rdata_cfg = 32'h0bad_beef;
    applyStimulus(1'b0, 14'h0, 32'h0, 1'b1, 14'h0002);
    tick();
    checkOutput("rrst_next_araddr", {16'h0, m_axi_araddr}, 32'h0000_0008);
    tick();
    tick();
    checkOutput("rrst_next_rack", {31'h0, up_rack}, 32'h1);
    checkOutput("rrst_next_rdata", up_rdata, 32'h0bad_beef);
    checkOutput("rrst_next_rerr", {31'h0, up_rerr}, 32'h0);
    up_rreq = 1'b0;
    tick();
    tick();
    checkOutput("rrst_rack_count", rack_cnt - rack_base, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_axi_master.md
# up_axi_master

Bus initiator that converts requests on the internal up register bus (up_wreq/up_rreq, 14-bit word addresses) into AXI4-Lite master transactions. It is the initiator counterpart of the up_axi slave bridge: it lets a local controller (calibration sequencer, profile switcher, soft CPU-less init engine) program the regmap of a TPL DAC/ADC core over its s_axi port. One transaction is outstanding at a time. A response timeout protects the requester against a hung slave.

## Interface
- AXI_ADDRESS_WIDTH, 16: m_axi_awaddr/araddr width. Byte address = {up_addr, 2'b00}, zero-extended or truncated to this width.
- TIMEOUT_CYCLES, 1023: cycles from leaving IDLE until forced abort. 0 disables the timeout.
- up_clk  in  1  clock for all logic.
- up_rstn  in  1  asynchronous active-low reset.
- up_wreq  in  1  write request; held until up_wack.
- up_waddr  in  14  word address.
- up_wdata  in  32  write data.
- up_wack  out  1  one-cycle write completion pulse.
- up_werr  out  1  valid with up_wack: bresp != OKAY, or timeout.
- up_rreq  in  1  read request; held until up_rack.
- up_raddr  in  14  word address.
- up_rdata  out  32  read data; valid with up_rack, held until the next read completes.
- up_rack  out  1  one-cycle read completion pulse.
- up_rerr  out  1  valid with up_rack: rresp != OKAY, or timeout.
- m_axi_awvalid/awready/awaddr/awprot  out/in/out/out  1/1/AW/3  write address; prot is fixed 3'b000.
- m_axi_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/32/4  write data; strb is fixed 4'hf.
- m_axi_bvalid/bready/bresp  in/out/in  1/1/2  write response.
- m_axi_arvalid/arready/araddr/arprot  out/in/out/out  1/1/AW/3  read address; prot is fixed 3'b000.
- m_axi_rvalid/rready/rdata/rresp  in/out/in/in  1/1/32/2  read response.

## Operation
- States: IDLE, WRITE, READ, ACK. All outputs are registered.
- IDLE:
  - up_wreq → WRITE. Capture waddr/wdata. Assert awvalid and wvalid.
  - Otherwise up_rreq → READ. Capture raddr. Assert arvalid.
  - Write has priority when both requests are high. The read stays pending and is served after the write's ACK.
- WRITE:
  - awvalid and wvalid are cleared independently on their own handshake (valid & ready). They never drop before their handshake except on timeout.
  - bready is 1 throughout WRITE.
  - On bvalid: up_werr ← (bresp != 2'b00); go to ACK.
- READ:
  - arvalid is cleared on its handshake. rready is 1 throughout READ.
  - On rvalid: up_rdata ← rdata; up_rerr ← (rresp != 2'b00); go to ACK.
- ACK:
  - Pulse up_wack or up_rack for exactly one cycle, then IDLE.
  - The requester must drop its request on the edge that samples the ack. IDLE therefore never re-issues a completed request.
- Timeout:
  - The counter clears in IDLE and increments in WRITE/READ.
  - At count == TIMEOUT_CYCLES: all valid and ready outputs drop, err ← 1, up_rdata ← 32'h0 for reads, go to ACK.
  - A late slave response after abort is not consumed. This is an accepted protocol breach for hung slaves only.
- Reset values: all AXI valid/ready outputs 0; awaddr/araddr/wdata 0; up_wack, up_rack, up_werr, up_rerr 0; up_rdata 0; state IDLE; counter 0.
- Reset mid-transaction: the block returns to IDLE asynchronously. No ack is issued.

## Timing
- Zero-wait slave (ready high, response one cycle after the address handshake):
  - Request sampled at edge 0.
  - AW/W (or AR) handshake at edge 1.
  - B (or R) handshake at edge 2.
  - Ack high in cycle 3.
- Minimum spacing is 4 cycles per transaction. A new request is sampled no earlier than the cycle after the ack.
- Ready-to-valid dependency: none. Valids never wait on readies.
- A B or R response arriving in the same cycle as the last address/data handshake is accepted; there is no ordering stall.

## Structure
- Package up_axi_master_pkg holds:
  - state encoding: IDLE=2'd0, WRITE=2'd1, READ=2'd2, ACK=2'd3;
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11.
- One flat module. The timeout counter is inline (width $clog2(TIMEOUT_CYCLES+1)). No sub-module.

## Test plan
- Reset: with up_rstn low mid-stream, all outputs read 0. Release, write 0x0040/0xA5A5_0001 → awaddr 0x0100, wdata 0xA5A5_0001, wstrb 0xf, up_wack in cycle 3, up_werr 0.
- Slave holds wready low 5 cycles after awready: awvalid clears after its handshake, wvalid stays high until wready, exactly one up_wack.
- Read 0x0010 with rdata 0x1234_5678, rresp 2'b10 → araddr 0x0040, up_rdata 0x1234_5678, up_rerr 1, up_rack one cycle.
- up_wreq and up_rreq raised in the same cycle → AW issued first, then AR after up_wack, giving one up_wack then one up_rack.
- TIMEOUT_CYCLES=8, slave never asserts bvalid → valids and bready drop at count 8, up_wack with up_werr 1, block back in IDLE.
- up_rstn pulsed while arvalid is high and arready is low → arvalid 0 immediately, no up_rack. The next read completes normally.
